// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-outstanding load/store unit between a CPU request port and a
//   byte-addressed memory bus. Each request passes through IDLE -> ACCESS -> RESP.
//   Illegal sizes skip ACCESS and return an error.
//   Misaligned half/word requests are handled in one of two ways, selected at build time:
//     - LSU_MISALIGNED_EN defined: the request is split into 2 or 4 single-byte
//       bus accesses.
//     - LSU_MISALIGNED_EN undefined: the request is rejected with resp_err.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : request handshake (accepted when both high at a rising edge)
//   req_we            : 1 = store, 0 = load
//   req_size          : 00 byte, 01 half, 10 word, 11 illegal
//   req_signed        : sign-extend byte/half loads
//   req_addr          : byte address
//   req_wdata         : right-aligned store data
//   resp_valid        : one-cycle completion pulse
//   resp_rdata        : load result (0 for stores/errors), held until next response
//   resp_err          : request rejected, held until next response
//   bus_addr          : bus byte address (IDLE_ADDR when no access in progress)
//   bus_wdata         : right-aligned bus write data
//   bus_write_enable  : one-hot strobe [0]=word [1]=half [2]=byte, 000 = read/idle
//   bus_rdata         : combinational read data, already right-aligned
module load_store_unit #(
  parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [2:0]  bus_write_enable,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misal;
  logic        w_err_req;
  logic        w_last;
  logic [31:0] w_raw;
  logic [31:0] w_ext;
  logic [2:0]  w_strobe;

  assign w_accept  = req_valid & req_ready;
  assign w_illegal = (req_size == 2'b11);
  assign w_misal   = ((req_size == 2'b01) & req_addr[0]) |
                     ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGNED_EN
  logic        r_split;
  logic [1:0]  r_cnt;
  logic [31:0] r_acc;
  logic [4:0]  w_shamt;

  assign w_err_req = w_illegal;
  assign w_shamt   = {r_cnt, 3'b000};
  // Final byte of a split: 2 bytes for a half, 4 for a word.
  assign w_last    = r_split ? (r_cnt == ((r_size == 2'b01) ? 2'd1 : 2'd3)) : 1'b1;
  // Split loads assemble the result one byte per cycle from bus_rdata[7:0].
  assign w_raw     = r_split ? (r_acc | ({24'h0, bus_rdata[7:0]} << w_shamt)) : bus_rdata;
`else
  assign w_err_req = w_illegal | w_misal;
  assign w_last    = 1'b1;
  assign w_raw     = bus_rdata;
`endif

  always_comb begin
    w_ext = w_raw;
    case (r_size)
      2'b00:   w_ext = {{24{r_signed & w_raw[7]}},  w_raw[7:0]};
      2'b01:   w_ext = {{16{r_signed & w_raw[15]}}, w_raw[15:0]};
      default: w_ext = w_raw;
    endcase
  end

  always_comb begin
    w_strobe = 3'b000;
    case (r_size)
      2'b00:   w_strobe = 3'b100;
      2'b01:   w_strobe = 3'b010;
      2'b10:   w_strobe = 3'b001;
      default: w_strobe = 3'b000;
    endcase
`ifdef LSU_MISALIGNED_EN
    if (r_split) w_strobe = 3'b100;
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = w_err_req ? S_RESP : S_ACCESS;
      S_ACCESS: if (w_last) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Control and response state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
`ifdef LSU_MISALIGNED_EN
      r_cnt   <= 2'd0;
`endif
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && w_accept && w_err_req) begin
        r_err   <= 1'b1;
        r_rdata <= 32'h0;
      end else if ((r_state == S_ACCESS) && w_last) begin
        r_err   <= 1'b0;
        r_rdata <= r_we ? 32'h0 : w_ext;
      end
`ifdef LSU_MISALIGNED_EN
      if (w_accept) r_cnt <= 2'd0;
      else if ((r_state == S_ACCESS) && !w_last) r_cnt <= r_cnt + 2'd1;
`endif
    end
  end

  // Latched request; only loaded on acceptance so later input changes are ignored
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we     <= req_we;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
`ifdef LSU_MISALIGNED_EN
      r_split  <= w_misal;
      r_acc    <= 32'h0;
    end else if ((r_state == S_ACCESS) && !w_last) begin
      r_acc    <= w_raw;
`endif
    end
  end

  // Bus outputs decode from state only, so reset takes effect immediately
  always_comb begin
    bus_addr         = IDLE_ADDR;
    bus_wdata        = 32'h0;
    bus_write_enable = 3'b000;
    if (r_state == S_ACCESS) begin
`ifdef LSU_MISALIGNED_EN
      bus_addr  = r_addr + {30'h0, r_cnt};
      bus_wdata = r_wdata >> w_shamt;
`else
      bus_addr  = r_addr;
      bus_wdata = r_wdata;
`endif
      bus_write_enable = r_we ? w_strobe : 3'b000;
    end
  end

  assign req_ready  = (r_state == S_IDLE) & rst_n;
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam logic [31:0] IDLE_A = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [2:0]  bus_write_enable;
  logic [31:0] bus_rdata;

  logic [31:0] tb_rdata;
  logic        tb_mem;

  // Simple bus model: fixed read word, or a per-address byte pattern for split loads
  assign bus_rdata = tb_mem ? {24'h0, bus_addr[7:0] ^ 8'hC3} : tb_rdata;

  load_store_unit #(.IDLE_ADDR(IDLE_A)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_write_enable(bus_write_enable), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem;
    int          e_lat;
    logic [2:0]  e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  int checks = 0;
  int failures = 0;

  int          o_lat;
  logic [31:0] o_rdata;
  logic        o_err;
  logic        o_anywe;
  logic [2:0]  cap_we [8];
  logic [31:0] cap_addr [8];
  logic [31:0] cap_wd [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic mem, input int e_lat,
                              input logic [2:0] e_we, input logic [31:0] e_addr,
                              input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                              input logic e_err);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.mem = mem; v.e_lat = e_lat; v.e_we = e_we; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_rdata = e_rdata; v.e_err = e_err;
    return v;
  endfunction

  // Issue one request, then scramble the inputs and record bus activity per cycle
  task automatic do_req(input vec_t v, input string nm);
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata; tb_rdata = v.rdata; tb_mem = v.mem;
    chk({nm, "_ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~v.we; req_size = 2'b10; req_signed = ~v.sgn;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_AAAA;
    o_lat = 99; o_rdata = 32'hX; o_err = 1'bX; o_anywe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cap_we[i] = 3'bX; cap_addr[i] = 32'hX; cap_wd[i] = 32'hX;
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 8) begin
        cap_we[c-1] = bus_write_enable; cap_addr[c-1] = bus_addr; cap_wd[c-1] = bus_wdata;
      end
      o_anywe = o_anywe | (|bus_write_enable);
      if (resp_valid) begin
        o_lat = c; o_rdata = resp_rdata; o_err = resp_err;
        break;
      end
    end
  endtask

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ready_mask;
    int rv_cnt;
    vec_t v;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; tb_rdata = 32'h0; tb_mem = 1'b0;

    vecs[0]  = mk(1, 2'b10, 0, 32'h1000_0008, 32'hDEAD_BEEF, 32'h0, 0, 2, 3'b001, 32'h1000_0008, 32'hDEAD_BEEF, 32'h0, 0);
    vecs[1]  = mk(0, 2'b00, 1, 32'h1000_0003, 32'h0, 32'h0000_0080, 0, 2, 3'b000, 32'h1000_0003, 32'h0, 32'hFFFF_FF80, 0);
    vecs[2]  = mk(0, 2'b00, 0, 32'h1000_0003, 32'h0, 32'h0000_0080, 0, 2, 3'b000, 32'h1000_0003, 32'h0, 32'h0000_0080, 0);
    vecs[3]  = mk(0, 2'b01, 1, 32'h1000_0002, 32'h0, 32'h1234_8001, 0, 2, 3'b000, 32'h1000_0002, 32'h0, 32'hFFFF_8001, 0);
    vecs[4]  = mk(0, 2'b01, 0, 32'h1000_0002, 32'h0, 32'h1234_8001, 0, 2, 3'b000, 32'h1000_0002, 32'h0, 32'h0000_8001, 0);
    vecs[5]  = mk(1, 2'b00, 0, 32'h0000_0003, 32'hAABB_CC5A, 32'h0, 0, 2, 3'b100, 32'h0000_0003, 32'hAABB_CC5A, 32'h0, 0);
    vecs[6]  = mk(1, 2'b01, 0, 32'h0000_0006, 32'h0000_BEEF, 32'h0, 0, 2, 3'b010, 32'h0000_0006, 32'h0000_BEEF, 32'h0, 0);
    vecs[7]  = mk(1, 2'b11, 0, 32'h0000_0100, 32'h1234_5678, 32'h0, 0, 1, 3'b000, IDLE_A, 32'h0, 32'h0, 1);
    vecs[8]  = mk(0, 2'b11, 1, 32'h0000_0200, 32'h0, 32'hFFFF_FFFF, 0, 1, 3'b000, IDLE_A, 32'h0, 32'h0, 1);
    vecs[9]  = mk(0, 2'b10, 0, 32'h2000_0000, 32'h0, 32'hCAFE_F00D, 0, 2, 3'b000, 32'h2000_0000, 32'h0, 32'hCAFE_F00D, 0);
`ifdef LSU_MISALIGNED_EN
    vecs[10] = mk(1, 2'b10, 0, 32'h1000_0001, 32'h1122_3344, 32'h0, 0, 5, 3'b100, 32'h1000_0001, 32'h1122_3344, 32'h0, 0);
    vecs[11] = mk(0, 2'b01, 1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1, 3, 3'b000, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_C33C, 0);
`else
    vecs[10] = mk(1, 2'b10, 0, 32'h1000_0001, 32'h1122_3344, 32'h0, 0, 1, 3'b000, IDLE_A, 32'h0, 32'h0, 1);
    vecs[11] = mk(0, 2'b01, 1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1, 1, 3'b000, IDLE_A, 32'h0, 32'h0, 1);
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_bus_addr", bus_addr, IDLE_A);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_bus_we", {29'h0, bus_write_enable}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", {31'h0, req_ready}, 32'h1);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      do_req(v, $sformatf("v%0d", i));
      chk($sformatf("v%0d_lat", i), o_lat, v.e_lat);
      chk($sformatf("v%0d_we", i), {29'h0, cap_we[0]}, {29'h0, v.e_we});
      chk($sformatf("v%0d_addr", i), cap_addr[0], v.e_addr);
      chk($sformatf("v%0d_wdata", i), cap_wd[0], v.e_wdata);
      chk($sformatf("v%0d_rdata", i), o_rdata, v.e_rdata);
      chk($sformatf("v%0d_err", i), {31'h0, o_err}, {31'h0, v.e_err});
      chk($sformatf("v%0d_anywe", i), {31'h0, o_anywe}, {31'h0, (v.e_we != 3'b000)});
    end

`ifdef LSU_MISALIGNED_EN
    // Split store: four byte writes at consecutive addresses
    do_req(vecs[10], "split_st");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("split_st_we%0d", k), {29'h0, cap_we[k]}, 32'h4);
      chk($sformatf("split_st_addr%0d", k), cap_addr[k], 32'h1000_0001 + k);
    end
    chk("split_st_b0", {24'h0, cap_wd[0][7:0]}, 32'h44);
    chk("split_st_b1", {24'h0, cap_wd[1][7:0]}, 32'h33);
    chk("split_st_b2", {24'h0, cap_wd[2][7:0]}, 32'h22);
    chk("split_st_b3", {24'h0, cap_wd[3][7:0]}, 32'h11);
    // Split load across the top of the address space wraps to 0
    do_req(vecs[11], "split_ld");
    chk("split_ld_addr1", cap_addr[1], 32'h0);
`endif

    // req_valid held high: one acceptance every 3 cycles
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0000_0040; tb_mem = 1'b0; tb_rdata = 32'h0000_0077;
    ready_mask = 0; rv_cnt = 0;
    for (int c = 0; c < 9; c++) begin
      if (req_ready) ready_mask = ready_mask | (1 << c);
      if (resp_valid) begin
        rv_cnt++;
        chk($sformatf("b2b_rdata%0d", c), resp_rdata, 32'h77);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_ready_mask", ready_mask, 32'h049);
    chk("b2b_resp_count", rv_cnt, 32'd3);
    repeat (3) @(negedge clk);

    // Reset in the middle of a store access
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h1000_0008; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mid_we_before", {29'h0, bus_write_enable}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_we_rst", {29'h0, bus_write_enable}, 32'h0);
    chk("mid_addr_rst", bus_addr, IDLE_A);
    chk("mid_ready_rst", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_ready_rel", {31'h0, req_ready}, 32'h1);
    rv_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) rv_cnt++;
    end
    chk("mid_no_resp", rv_cnt, 32'd0);
    chk("mid_err", {31'h0, resp_err}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
